// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory access stage: control_unit field
// encodings, load/store unit FSM states and address-alignment helpers.
package riscv_pkg;

  // whb field from control_unit
  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;
  localparam logic [1:0] WHB_ILL  = 2'b11;

  // rw field from control_unit
  localparam logic RW_LOAD  = 1'b1;
  localparam logic RW_STORE = 1'b0;

  // load_store_unit FSM encodings
  localparam logic [1:0] LSU_IDLE = 2'b00;
  localparam logic [1:0] LSU_REQ  = 2'b01;
  localparam logic [1:0] LSU_RESP = 2'b10;

  // Fields of an accepted access that the response path still needs.
  typedef struct packed {
    logic       rw;
    logic [1:0] whb;
    logic       su;
    logic [1:0] lo;
  } lsu_op_t;

  // True when the access size does not fit its natural alignment.
  function automatic logic is_misaligned(input logic [1:0] whb, input logic [1:0] lo);
    logic mis;
    case (whb)
      WHB_HALF: mis = lo[0];
      WHB_WORD: mis = (lo != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Clears the low address bits that would misalign the access.
  function automatic logic [1:0] align_lo(input logic [1:0] whb, input logic [1:0] lo);
    logic [1:0] res;
    case (whb)
      WHB_HALF: res = {lo[1], 1'b0};
      WHB_WORD: res = 2'b00;
      default:  res = lo;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: byte enables and
// replicated store data on the way out, lane extraction and sign/zero
// extension of the returned word on the way back.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_whb,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_whb,
  input  logic [1:0]  ld_lo,
  input  logic        ld_su,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: enable the addressed lanes and replicate data across all lanes.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = 32'h0000_0000;
    case (st_whb)
      WHB_BYTE: begin
        st_be    = 4'b0001 << st_lo;
        st_lanes = {4{st_wdata[7:0]}};
      end
      WHB_HALF: begin
        st_be    = 4'b0011 << {st_lo[1], 1'b0};
        st_lanes = {2{st_wdata[15:0]}};
      end
      WHB_WORD: begin
        st_be    = 4'b1111;
        st_lanes = st_wdata;
      end
      default: begin
        st_be    = 4'b0000;
        st_lanes = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_sel = ld_word[{ld_lo, 3'b000} +: 8];
    half_sel = ld_word[{ld_lo[1], 4'b0000} +: 16];
    ld_data  = 32'h0000_0000;
    case (ld_whb)
      WHB_BYTE: ld_data = {{24{ld_su & byte_sel[7]}}, byte_sel};
      WHB_HALF: ld_data = {{16{ld_su & half_sel[15]}}, half_sel};
      WHB_WORD: ld_data = ld_word;
      default:  ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage. Accepts one load/store per start pulse, runs a
// req/ack memory handshake with a timeout, and returns extended load data.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned half/word accesses
// finish with err instead of having their low address bits cleared.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  whb,
  input  logic        su,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Last counter value before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  lsu_op_t     op;
  logic        bad;
  logic [7:0]  cnt;

  logic        start_bad;
  logic [1:0]  eff_lo;
  logic [3:0]  st_be;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;

`ifdef MISALIGN_TRAP_EN
  // Misaligned accesses are rejected and keep their original address bits.
  always_comb begin
    start_bad = (whb == WHB_ILL) || is_misaligned(whb, addr[1:0]);
    eff_lo    = addr[1:0];
  end
`else
  // Misaligned accesses are silently realigned; only whb==11 is rejected.
  always_comb begin
    start_bad = (whb == WHB_ILL);
    eff_lo    = align_lo(whb, addr[1:0]);
  end
`endif

  // Store steering uses the live request; load extraction the latched one.
  lsu_align u_align (
    .st_whb   (whb),
    .st_lo    (eff_lo),
    .st_wdata (wdata),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_whb   (op.whb),
    .ld_lo    (op.lo),
    .ld_su    (op.su),
    .ld_word  (mem_rdata),
    .ld_data  (ld_data)
  );

  // Access FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LSU_IDLE;
      op        <= '0;
      bad       <= 1'b0;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0000_0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      done <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (start) begin
            op.rw     <= rw;
            op.whb    <= whb;
            op.su     <= su;
            op.lo     <= eff_lo;
            bad       <= start_bad;
            err       <= 1'b0;
            busy      <= 1'b1;
            cnt       <= 8'd0;
            state     <= LSU_REQ;
            mem_req   <= ~start_bad;
            mem_we    <= ~start_bad & (rw == RW_STORE);
            mem_be    <= start_bad ? 4'b0000 : st_be;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= st_lanes;
          end else begin
            busy <= 1'b0;
          end
        end
        LSU_REQ: begin
          if (bad) begin
            // Rejected access: one cycle of busy, then an error completion.
            state <= LSU_RESP;
            done  <= 1'b1;
            err   <= 1'b1;
            if (op.rw == RW_LOAD) begin
              rdata <= 32'h0000_0000;
            end else begin
              rdata <= rdata;
            end
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= LSU_RESP;
            done    <= 1'b1;
            if (op.rw == RW_LOAD) begin
              rdata <= ld_data;
            end else begin
              rdata <= rdata;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            // Memory never answered: abandon the request.
            mem_req <= 1'b0;
            state   <= LSU_RESP;
            done    <= 1'b1;
            err     <= 1'b1;
            if (op.rw == RW_LOAD) begin
              rdata <= 32'h0000_0000;
            end else begin
              rdata <= rdata;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LSU_RESP: begin
          state <= LSU_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= LSU_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rw;
  logic [1:0]  whb;
  logic        su;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          failures = 0;
  int          done_c;
  logic        saw_req;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .whb       (whb),
    .su        (su),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the falling edge of cycle T+1
  // with the memory-side fields of that cycle captured.
  task automatic kick(input logic k_rw, input logic [1:0] k_whb, input logic k_su,
                      input logic [31:0] k_addr, input logic [31:0] k_wdata);
    @(negedge clk);
    rw = k_rw; whb = k_whb; su = k_su; addr = k_addr; wdata = k_wdata;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    saw_req   = mem_req;
    cap_we    = mem_we;
    cap_be    = mem_be;
    cap_addr  = mem_addr;
    cap_wdata = mem_wdata;
  endtask

  // Drive mem_ack in cycle T+ack_at (0 = never) and return at the falling
  // edge where done is seen, recording its cycle number in done_c.
  task automatic finish_op(input int c0, input int ack_at, input logic [31:0] word);
    done_c = -1;
    for (int c = c0; c <= 400; c++) begin
      if (mem_req) saw_req = 1'b1;
      if (done) begin
        done_c = c;
        break;
      end
      mem_ack   = (c == ack_at);
      mem_rdata = word;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (done_c < 0) check_eq("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; whb = 2'b00; su = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  {31'b0, busy},    32'd0);
    check_eq("rst_done",  {31'b0, done},    32'd0);
    check_eq("rst_err",   {31'b0, err},     32'd0);
    check_eq("rst_req",   {31'b0, mem_req}, 32'd0);
    check_eq("rst_we",    {31'b0, mem_we},  32'd0);
    check_eq("rst_be",    {28'b0, mem_be},  32'd0);
    check_eq("rst_addr",  mem_addr,         32'd0);
    check_eq("rst_wdata", mem_wdata,        32'd0);
    check_eq("rst_rdata", rdata,            32'd0);
    rst = 1'b0;

    // LW 0x100, ack in T+3
    kick(RW_LOAD, WHB_WORD, 1'b0, 32'h0000_0100, 32'h0);
    check_eq("lw_req",  {31'b0, saw_req}, 32'd1);
    check_eq("lw_busy", {31'b0, busy},    32'd1);
    check_eq("lw_be",   {28'b0, cap_be},  32'h0000_000F);
    check_eq("lw_addr", cap_addr,         32'h0000_0100);
    check_eq("lw_we",   {31'b0, cap_we},  32'd0);
    finish_op(1, 3, 32'hDEAD_BEEF);
    check_eq("lw_done_cyc", done_c, 32'd4);
    check_eq("lw_rdata", rdata, 32'hDEAD_BEEF);
    check_eq("lw_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    check_eq("lw_done_pulse", {31'b0, done}, 32'd0);
    check_eq("lw_busy_end",   {31'b0, busy}, 32'd0);

    // LB / LBU 0x103
    kick(RW_LOAD, WHB_BYTE, 1'b1, 32'h0000_0103, 32'h0);
    check_eq("lb_be", {28'b0, cap_be}, 32'h0000_0008);
    finish_op(1, 1, 32'h80FF_FFFF);
    check_eq("lb_done_cyc", done_c, 32'd2);
    check_eq("lb_rdata", rdata, 32'hFFFF_FF80);
    kick(RW_LOAD, WHB_BYTE, 1'b0, 32'h0000_0103, 32'h0);
    finish_op(1, 1, 32'h80FF_FFFF);
    check_eq("lbu_rdata", rdata, 32'h0000_0080);

    // LH upper lane signed, LHU lower lane
    kick(RW_LOAD, WHB_HALF, 1'b1, 32'h0000_0102, 32'h0);
    check_eq("lh_be", {28'b0, cap_be}, 32'h0000_000C);
    finish_op(1, 2, 32'h8001_1234);
    check_eq("lh_rdata", rdata, 32'hFFFF_8001);
    kick(RW_LOAD, WHB_HALF, 1'b0, 32'h0000_0100, 32'h0);
    check_eq("lhu_be", {28'b0, cap_be}, 32'h0000_0003);
    finish_op(1, 2, 32'h8001_F234);
    check_eq("lhu_rdata", rdata, 32'h0000_F234);

    // SH 0x102: rdata must keep the previous load value
    kick(RW_STORE, WHB_HALF, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
    check_eq("sh_we",    {31'b0, cap_we}, 32'd1);
    check_eq("sh_be",    {28'b0, cap_be}, 32'h0000_000C);
    check_eq("sh_wdata", cap_wdata,       32'hABCD_ABCD);
    check_eq("sh_addr",  cap_addr,        32'h0000_0100);
    finish_op(1, 2, 32'h5555_5555);
    check_eq("sh_done_cyc", done_c, 32'd3);
    check_eq("sh_rdata", rdata, 32'h0000_F234);
    check_eq("sh_err", {31'b0, err}, 32'd0);

    // SB 0x101, SW 0x104
    kick(RW_STORE, WHB_BYTE, 1'b0, 32'h0000_0101, 32'h0000_00A5);
    check_eq("sb_be",    {28'b0, cap_be}, 32'h0000_0002);
    check_eq("sb_wdata", cap_wdata,       32'hA5A5_A5A5);
    finish_op(1, 1, 32'h0);
    kick(RW_STORE, WHB_WORD, 1'b0, 32'h0000_0104, 32'hCAFE_F00D);
    check_eq("sw_be",    {28'b0, cap_be}, 32'h0000_000F);
    check_eq("sw_addr",  cap_addr,        32'h0000_0104);
    check_eq("sw_wdata", cap_wdata,       32'hCAFE_F00D);
    finish_op(1, 1, 32'h0);

    // Misaligned LW 0x101 and LH 0x103
    kick(RW_LOAD, WHB_WORD, 1'b0, 32'h0000_0101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    finish_op(1, 2, 32'h1122_3344);
    check_eq("mis_lw_req",  {31'b0, saw_req}, 32'd0);
    check_eq("mis_lw_cyc",  done_c,           32'd2);
    check_eq("mis_lw_err",  {31'b0, err},     32'd1);
    check_eq("mis_lw_data", rdata,            32'd0);
    kick(RW_LOAD, WHB_HALF, 1'b0, 32'h0000_0103, 32'h0);
    finish_op(1, 2, 32'hBEEF_0000);
    check_eq("mis_lh_req", {31'b0, saw_req}, 32'd0);
    check_eq("mis_lh_err", {31'b0, err},     32'd1);
`else
    check_eq("mis_lw_addr", cap_addr,        32'h0000_0100);
    check_eq("mis_lw_be",   {28'b0, cap_be}, 32'h0000_000F);
    finish_op(1, 2, 32'h1122_3344);
    check_eq("mis_lw_cyc",  done_c,       32'd3);
    check_eq("mis_lw_err",  {31'b0, err}, 32'd0);
    check_eq("mis_lw_data", rdata,        32'h1122_3344);
    kick(RW_LOAD, WHB_HALF, 1'b0, 32'h0000_0103, 32'h0);
    check_eq("mis_lh_be", {28'b0, cap_be}, 32'h0000_000C);
    finish_op(1, 2, 32'hBEEF_0000);
    check_eq("mis_lh_data", rdata,        32'h0000_BEEF);
    check_eq("mis_lh_err",  {31'b0, err}, 32'd0);
`endif

    // Illegal whb
    kick(RW_LOAD, WHB_ILL, 1'b0, 32'h0000_0100, 32'h0);
    finish_op(1, 0, 32'h0);
    check_eq("ill_req",  {31'b0, saw_req}, 32'd0);
    check_eq("ill_cyc",  done_c,           32'd2);
    check_eq("ill_err",  {31'b0, err},     32'd1);
    check_eq("ill_data", rdata,            32'd0);

    // Timeout: mem_req high for 255 cycles, done in T+256
    kick(RW_LOAD, WHB_WORD, 1'b0, 32'h0000_0200, 32'h0);
    finish_op(1, 0, 32'h0);
    check_eq("to_req",    {31'b0, saw_req}, 32'd1);
    check_eq("to_cyc",    done_c,           32'd256);
    check_eq("to_err",    {31'b0, err},     32'd1);
    check_eq("to_req_dn", {31'b0, mem_req}, 32'd0);

    // Start while busy is ignored; err cleared by the new start
    kick(RW_LOAD, WHB_WORD, 1'b0, 32'h0000_0300, 32'h0);
    check_eq("clr_err", {31'b0, err}, 32'd0);
    rw = RW_STORE; whb = WHB_BYTE; addr = 32'h0000_0401; start = 1'b1;
    @(negedge clk);
    check_eq("busy_start_addr", mem_addr,         32'h0000_0300);
    check_eq("busy_start_be",   {28'b0, mem_be},  32'h0000_000F);
    check_eq("busy_start_we",   {31'b0, mem_we},  32'd0);
    start = 1'b0;
    finish_op(2, 3, 32'h0BAD_F00D);
    check_eq("busy_start_cyc",  done_c, 32'd4);
    check_eq("busy_start_data", rdata,  32'h0BAD_F00D);

    // Stray ack in IDLE
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    repeat (3) @(negedge clk);
    check_eq("stray_busy",  {31'b0, busy},    32'd0);
    check_eq("stray_done",  {31'b0, done},    32'd0);
    check_eq("stray_rdata", rdata,            32'h0BAD_F00D);
    mem_ack = 1'b0;

    // Reset mid-access drops mem_req immediately
    kick(RW_LOAD, WHB_WORD, 1'b0, 32'h0000_0500, 32'h0);
    check_eq("mid_req_before", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_req",   {31'b0, mem_req}, 32'd0);
    check_eq("mid_rst_busy",  {31'b0, busy},    32'd0);
    check_eq("mid_rst_rdata", rdata,            32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
